pe_sched: RTL and testbench

- Controller that sequences the pre-emphasis filter (pm_filter) in the front-end audio chain.
- Accepts raw PCM samples over a valid/ready stream and issues one sample per filter step via a filter enable strobe.
- Captures each filtered output and emits it framed (sof/eof), with back-pressure.
- Manages utterance start (filter flush/reset) and stop (zero-pad the final partial frame).

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_frame_ctr.sv | 39 +++
 rtl/pe_sched.sv | 142 ++++++++++++++
 tb/tb_pe_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, FSM state encoding and index-width helper for the pre-emphasis scheduler
package pe_pkg;

    localparam int PE_DATA_W    = 16;
    localparam int PE_FILT_LAT  = 2;
    localparam int PE_FRAME_LEN = 400;
    localparam int PE_FLUSH_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4,
        ST_PAD    = 3'd5
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_frame_ctr.sv
// pe_frame_ctr: in-frame sample index and completed-frame counter with sof/eof/last flags
module pe_frame_ctr
    import pe_pkg::*;
#(
    parameter int FRAME_LEN = PE_FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_step,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_last,
    output logic [15:0] o_frame_cnt
);

    localparam int IW = idx_w(FRAME_LEN);

    logic [IW-1:0] r_idx;

    assign o_sof  = r_idx == '0;
    assign o_eof  = r_idx == IW'(FRAME_LEN - 1);
    assign o_last = i_step && o_eof;

    // advance the index per emitted sample, wrapping and counting a frame at its last sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            o_frame_cnt <= '0;
        end else if (i_clr) begin
            r_idx       <= '0;
            o_frame_cnt <= '0;
        end else if (i_step) begin
            r_idx       <= o_eof ? '0 : r_idx + 1'b1;
            o_frame_cnt <= o_eof ? o_frame_cnt + 16'd1 : o_frame_cnt;
        end
    end

endmodule

// File: rtl/pe_sched.sv
// pe_sched: sequences the pre-emphasis filter one sample at a time and frames its output; PE_SCHED_STATS_EN adds sample/stall counters
module pe_sched
    import pe_pkg::*;
#(
    parameter int DATA_W    = PE_DATA_W,
    parameter int FILT_LAT  = PE_FILT_LAT,
    parameter int FRAME_LEN = PE_FRAME_LEN,
    parameter int FLUSH_CYC = PE_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              filt_rst,
    output logic              filt_en,
    output logic [DATA_W-1:0] filt_x,
    input  logic [DATA_W-1:0] filt_y,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
`ifdef PE_SCHED_STATS_EN
    output logic [31:0]       stat_samples,
    output logic [31:0]       stat_stall,
`endif
    output logic [15:0]       frame_cnt
);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_stop_pend;
    logic        w_start, w_hs_in, w_hs_out, w_stop, w_to_idle;
    logic        w_sof, w_eof, w_last;

    assign s_ready   = r_state == ST_ACCEPT;
    assign busy      = r_state != ST_IDLE;
    assign w_start   = (r_state == ST_IDLE) && start;
    assign w_hs_in   = s_valid && s_ready;
    assign w_hs_out  = m_valid && m_ready;
    assign w_stop    = r_stop_pend || stop;
    assign w_to_idle = ((r_state == ST_ACCEPT) && !w_hs_in && r_stop_pend && w_sof) ||
                       ((r_state == ST_OUT) && w_hs_out && w_stop && w_last);

    pe_frame_ctr #(.FRAME_LEN(FRAME_LEN)) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_step      (w_hs_out),
        .o_sof       (w_sof),
        .o_eof       (w_eof),
        .o_last      (w_last),
        .o_frame_cnt (frame_cnt)
    );

    // a stop while busy is remembered until the FSM lands back in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stop_pend <= 1'b0;
        else      r_stop_pend <= busy && !w_to_idle && w_stop;
    end

    // control FSM: flush, accept one sample, wait out the filter latency, present it, pad on stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            filt_rst <= 1'b1;
            filt_en  <= 1'b0;
            filt_x   <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
        end else begin
            filt_en <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= 16'(FLUSH_CYC - 1);
                    filt_x  <= '0;
                end
                ST_FLUSH: if (r_cnt == '0) begin
                    r_state  <= ST_ACCEPT;
                    filt_rst <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                ST_ACCEPT: if (w_hs_in) begin
                    r_state <= ST_WAIT;
                    r_cnt   <= 16'(FILT_LAT - 1);
                    filt_x  <= s_data;
                    filt_en <= 1'b1;
                end else if (r_stop_pend) begin
                    r_state  <= w_sof ? ST_IDLE : ST_PAD;
                    filt_rst <= w_sof;
                end
                ST_PAD: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= 16'(FILT_LAT - 1);
                    filt_x  <= '0;
                    filt_en <= 1'b1;
                end
                ST_WAIT: if (r_cnt == '0) begin
                    r_state <= ST_OUT;
                    m_valid <= 1'b1;
                    m_data  <= filt_y;
                    m_sof   <= w_sof;
                    m_eof   <= w_eof;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                ST_OUT: if (m_ready) begin
                    m_valid  <= 1'b0;
                    r_state  <= w_stop ? (w_last ? ST_IDLE : ST_PAD) : ST_ACCEPT;
                    filt_rst <= w_stop && w_last;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PE_SCHED_STATS_EN
    // saturating counters of accepted samples and output stall cycles, cleared per utterance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_samples <= '0;
            stat_stall   <= '0;
        end else if (w_start) begin
            stat_samples <= '0;
            stat_stall   <= '0;
        end else begin
            stat_samples <= (w_hs_in && !(&stat_samples)) ? stat_samples + 32'd1 : stat_samples;
            stat_stall   <= (m_valid && !m_ready && !(&stat_stall)) ? stat_stall + 32'd1 : stat_stall;
        end
    end
`endif

endmodule

// File: tb/tb_pe_sched.sv
// tb_pe_sched: directed bench for pe_sched with a filter stand-in and a frame-level output model
module tb_pe_sched;

    localparam int FL = 4;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic        s_valid = 1'b0, m_ready = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_ready, filt_rst, filt_en, m_valid, m_sof, m_eof, busy;
    logic [15:0] filt_x, filt_y, m_data, frame_cnt;
`ifdef PE_SCHED_STATS_EN
    logic [31:0] stat_samples, stat_stall;
`endif

    pe_sched #(.DATA_W(16), .FILT_LAT(2), .FRAME_LEN(FL), .FLUSH_CYC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .filt_rst     (filt_rst),
        .filt_en      (filt_en),
        .filt_x       (filt_x),
        .filt_y       (filt_y),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .busy         (busy),
`ifdef PE_SCHED_STATS_EN
        .stat_samples (stat_samples),
        .stat_stall   (stat_stall),
`endif
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // pre-emphasis filter stand-in y = x - x_prev/2 with one register stage (two-edge latency)
    logic signed [15:0] p_prev = '0, p_y = '0;
    always @(posedge clk) begin
        if (filt_rst) begin
            p_prev <= '0;
            p_y    <= '0;
        end else if (filt_en) begin
            p_y    <= $signed(filt_x) - (p_prev >>> 1);
            p_prev <= $signed(filt_x);
        end
    end
    assign filt_y = p_y;

    typedef struct {
        logic [15:0] d;
        bit          sof;
        bit          eof;
    } exp_t;

    exp_t               exp_q[$];
    logic [15:0]        out_log[$];
    bit                 sof_log[$];
    bit                 eof_log[$];
    longint             en_t[$];
    logic signed [15:0] m_prev;
    int                 m_acc;
    int                 n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, want);
        end
    endtask

    function automatic void model_start();
        m_prev = '0;
        m_acc  = 0;
    endfunction

    function automatic void model_push(input logic [15:0] x);
        logic signed [15:0] y;
        y = $signed(x) - (m_prev >>> 1);
        exp_q.push_back('{d: y, sof: (m_acc % FL) == 0, eof: (m_acc % FL) == FL - 1});
        m_prev = $signed(x);
        m_acc++;
    endfunction

    function automatic void model_stop();
        while (m_acc % FL != 0) model_push(16'h0000);
    endfunction

    // every output handshake is checked against the model stream
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(e.d));
                chk("m_sof", 32'(m_sof), 32'(e.sof));
                chk("m_eof", 32'(m_eof), 32'(e.eof));
            end
            out_log.push_back(m_data);
            sof_log.push_back(m_sof);
            eof_log.push_back(m_eof);
        end
    end

    always @(negedge clk) if (filt_en) en_t.push_back(longint'($time));

    task automatic pulse(input logic st, input logic sp);
        @(posedge clk); #1;
        start = st;
        stop  = sp;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic send(input logic [15:0] x);
        bit ok = 0;
        s_data  = x;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
        if (ok) model_push(x);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            @(negedge clk);
            if (filt_en) chk("pad_filt_x", 32'(filt_x), 32'd0);
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_mvalid();
        for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
        chk("m_valid_seen", 32'(m_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_rst, snap;
        logic [15:0] d0;
        logic        s0, e0;

        // reset values, then idle without start
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_filt_rst", 32'(filt_rst), 32'd1);
        chk("rst_filt_en", 32'(filt_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // one full frame: flush length, strobe spacing, filtered values
        en_t.delete();
        out_log.delete();
        sof_log.delete();
        eof_log.delete();
        pulse(1'b1, 1'b0);
        model_start();
        n_rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!filt_rst) break;
            n_rst++;
        end
        chk("flush_len", 32'(n_rst), 32'd2);
        chk("busy_run", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send(16'h1000);
        send(16'h2000);
        send(16'h3000);
        send(16'h4000);
        drain();
        chk("en_count", 32'(en_t.size()), 32'd4);
        for (int i = 1; i < en_t.size(); i++) chk("en_spacing", 32'(en_t[i] - en_t[i-1]), 32'd40);
        chk("f1_y0", 32'(out_log[0]), 32'h1000);
        chk("f1_y1", 32'(out_log[1]), 32'h1800);
        chk("f1_y2", 32'(out_log[2]), 32'h2000);
        chk("f1_y3", 32'(out_log[3]), 32'h2800);
        chk("f1_sof0", 32'(sof_log[0]), 32'd1);
        chk("f1_eof3", 32'(eof_log[3]), 32'd1);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

        // start while busy is ignored; stop on a frame boundary goes straight to idle
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("busy_start_cnt", 32'(frame_cnt), 32'd1);
        chk("busy_start_busy", 32'(busy), 32'd1);
        snap = en_t.size();
        pulse(1'b0, 1'b1);
        wait_idle();
        chk("bound_no_pad", 32'(en_t.size() - snap), 32'd0);
        chk("bound_frame_cnt", 32'(frame_cnt), 32'd1);
        pulse(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_cnt", 32'(frame_cnt), 32'd1);
        chk("idle_stop_filt_rst", 32'(filt_rst), 32'd1);
        chk("idle_stop_s_ready", 32'(s_ready), 32'd0);

        // fresh utterance: back-pressure on the first sample, then stop after two samples
        out_log.delete();
        sof_log.delete();
        eof_log.delete();
        pulse(1'b1, 1'b0);
        model_start();
        @(negedge clk);
        chk("restart_cnt", 32'(frame_cnt), 32'd0);
        m_ready = 1'b0;
        @(posedge clk); #1;
        send(16'h0400);
        wait_mvalid();
        snap = en_t.size();
        d0 = m_data;
        s0 = m_sof;
        e0 = m_eof;
        chk("bp_data", 32'(d0), 32'h0400);
        chk("bp_sof", 32'(s0), 32'd1);
        chk("bp_eof", 32'(e0), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_data", 32'(m_data), 32'(d0));
            chk("bp_hold_flags", 32'({m_sof, m_eof}), 32'({s0, e0}));
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        chk("bp_no_extra_en", 32'(en_t.size() - snap), 32'd0);
        send(16'h0200);
        drain();
        snap = en_t.size();
        pulse(1'b0, 1'b1);
        model_stop();
        wait_idle();
        drain();
        chk("pad_pulses", 32'(en_t.size() - snap), 32'd2);
        chk("pad_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("pad_y1", 32'(out_log[1]), 32'h0000);
        chk("pad_y2", 32'(out_log[2]), 32'hFF00);
        chk("pad_y3", 32'(out_log[3]), 32'h0000);
        chk("pad_eof3", 32'(eof_log[3]), 32'd1);
`ifdef PE_SCHED_STATS_EN
        chk("stat_stall", stat_stall, 32'd10);
        chk("stat_samples", stat_samples, 32'd2);
`endif

        // simultaneous start and stop in idle: start wins, no pending stop
        pulse(1'b1, 1'b1);
        model_start();
        @(negedge clk);
        chk("ss_busy", 32'(busy), 32'd1);
        chk("ss_filt_rst", 32'(filt_rst), 32'd1);
        chk("ss_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (6) @(negedge clk);
        chk("ss_accept", 32'(s_ready), 32'd1);
        chk("ss_still_busy", 32'(busy), 32'd1);

        // asynchronous reset while a sample waits in OUT
        m_ready = 1'b0;
        @(posedge clk); #1;
        send(16'h7000);
        wait_mvalid();
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("ar_s_ready", 32'(s_ready), 32'd0);
        chk("ar_filt_rst", 32'(filt_rst), 32'd1);
        chk("ar_filt_en", 32'(filt_en), 32'd0);
        chk("ar_filt_x", 32'(filt_x), 32'd0);
        chk("ar_m_valid", 32'(m_valid), 32'd0);
        chk("ar_m_data", 32'(m_data), 32'd0);
        chk("ar_flags", 32'({m_sof, m_eof}), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("model_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
